// File: rtl/csr_req_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : csr_req_pkg
// Purpose : Shared command/result types and widths for the CSR req initiator.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package csr_req_pkg;

  localparam int CSR_ADDR_W = 3;
  localparam int CSR_DATA_W = 32;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] data;
    logic                  wr_en;
  } csr_cmd_t;

  typedef struct packed {
    logic [CSR_DATA_W-1:0] data;
    logic                  wr;
  } csr_res_t;

  localparam int CSR_CMD_W = $bits(csr_cmd_t);
  localparam int CSR_RES_W = $bits(csr_res_t);

endpackage
`default_nettype wire

// File: rtl/csr_req_rsp_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : csr_req_rsp_fifo
// Purpose : Synchronous FIFO with full/empty/count; DEPTH must be a power of 2.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module csr_req_rsp_fifo
  import csr_req_pkg::*;
#(
  parameter int WIDTH = CSR_RES_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == c_depth);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/csr_req_initiator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : csr_req_initiator
// Purpose : Host-to-CSR request initiator with in-order result return.
//           Optional sticky watchdog enabled by CSR_REQ_TIMEOUT_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module csr_req_initiator
  import csr_req_pkg::*;
#(
  parameter int RegAddrWidth  = CSR_ADDR_W,
  parameter int RegDataWidth  = CSR_DATA_W,
  parameter int RspFifoDepth  = 4,
  parameter int TimeoutCycles = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RegAddrWidth-1:0] cmd_addr_i,
  input  logic [RegDataWidth-1:0] cmd_data_i,
  input  logic                    cmd_wr_en_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  output logic [RegDataWidth-1:0] res_data_o,
  output logic                    res_wr_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [RegAddrWidth-1:0] csr_addr_o,
  output logic [RegDataWidth-1:0] csr_wr_data_o,
  output logic                    csr_wr_en_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [RegDataWidth-1:0] csr_rd_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  output logic                    timeout_o
);

  localparam int CNT_W = $clog2(RspFifoDepth) + 1;
  localparam logic [CNT_W-1:0] c_max_inflight = CNT_W'(RspFifoDepth);

  csr_cmd_t         r_req;
  logic             r_req_valid;
  logic [CNT_W-1:0] r_inflight;
  logic             w_timeout;

  logic             w_cmd_hs;
  logic             w_req_hs;
  logic             w_rsp_hs;
  logic             w_res_hs;

  csr_res_t         w_res_push;
  csr_res_t         w_res_head;
  logic             w_res_full;
  logic             w_res_empty;
  logic [CNT_W-1:0] w_res_count;

  logic             w_tag_head;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic [CNT_W-1:0] w_tag_count;

  // Credits cover every command until its result has left toward the host.
  assign cmd_ready_o = (!r_req_valid || csr_req_ready_i)
                       && (r_inflight < c_max_inflight)
                       && !w_timeout;

  assign w_cmd_hs = cmd_valid_i && cmd_ready_o;
  assign w_req_hs = r_req_valid && csr_req_ready_i;
  assign w_rsp_hs = csr_rsp_valid_i && csr_rsp_ready_o;
  assign w_res_hs = res_valid_o && res_ready_i;

  assign csr_addr_o      = r_req.addr;
  assign csr_wr_data_o   = r_req.data;
  assign csr_wr_en_o     = r_req.wr_en;
  assign csr_req_valid_o = r_req_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req       <= '0;
      r_req_valid <= 1'b0;
    end else if (w_cmd_hs) begin
      r_req       <= '{addr: cmd_addr_i, data: cmd_data_i, wr_en: cmd_wr_en_i};
      r_req_valid <= 1'b1;
    end else if (w_req_hs) begin
      r_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= '0;
    end else begin
      case ({w_cmd_hs, w_res_hs})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // The tag queue remembers wr_en of each issued request until its response arrives.
  csr_req_rsp_fifo #(
    .WIDTH (1),
    .DEPTH (RspFifoDepth)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_req_hs),
    .data_i  (r_req.wr_en),
    .pop_i   (w_rsp_hs),
    .data_o  (w_tag_head),
    .full_o  (w_tag_full),
    .empty_o (w_tag_empty),
    .count_o (w_tag_count)
  );

  assign w_res_push = '{data: csr_rd_data_i, wr: w_tag_head};

  csr_req_rsp_fifo #(
    .WIDTH (CSR_RES_W),
    .DEPTH (RspFifoDepth)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_rsp_hs),
    .data_i  (w_res_push),
    .pop_i   (w_res_hs),
    .data_o  (w_res_head),
    .full_o  (w_res_full),
    .empty_o (w_res_empty),
    .count_o (w_res_count)
  );

  assign csr_rsp_ready_o = !w_res_full;
  assign res_valid_o     = !w_res_empty;
  // Memory contents survive reset, so the head is masked while the FIFO is empty.
  assign res_data_o      = w_res_empty ? '0 : w_res_head.data;
  assign res_wr_o        = !w_res_empty && w_res_head.wr;

`ifdef CSR_REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TimeoutCycles + 1);
  localparam logic [WD_W-1:0] c_wd_max = WD_W'(TimeoutCycles);

  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_next;
  logic            r_timeout;

  always_comb begin
    w_wd_next = r_wd_cnt;
    if (w_rsp_hs) begin
      w_wd_next = '0;
    end else if ((r_inflight != '0) && (r_wd_cnt != c_wd_max)) begin
      w_wd_next = r_wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_next;
      r_timeout <= r_timeout || (w_wd_next == c_wd_max);
    end
  end

  assign w_timeout = r_timeout;

  logic w_unused_cfg;
  assign w_unused_cfg = 1'b0;
`else
  assign w_timeout = 1'b0;

  logic w_unused_cfg;
  assign w_unused_cfg = TimeoutCycles[0];
`endif

  assign timeout_o = w_timeout;

  logic w_unused;
  assign w_unused = ^{w_tag_full, w_tag_empty, w_tag_count, w_res_count, w_unused_cfg};

endmodule
`default_nettype wire
